// File: rtl/nn_pkg.sv
// Shared types and sizes for the digit-recognition datapath.
package nn_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int PROB_W      = 16;

  typedef logic [PROB_W-1:0] prob_t;
  typedef logic [3:0]        digit_t;

  // Argmax scanner state machine encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } sel_state_t;

  // Index of the final entry visited by the scan.
  localparam digit_t LAST_IDX = digit_t'(NUM_CLASSES - 1);

endpackage : nn_pkg

// File: rtl/prediction_filter.sv
// Debounces successive confident predictions: the displayed digit changes
// only after the same confident winner has been seen STABLE_COUNT times in a row.
module prediction_filter
  import nn_pkg::*;
#(
  parameter int STABLE_COUNT = 4
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   Update,
  input  digit_t Digit,
  input  logic   Confident,
  output digit_t Stable_Digit,
  output logic   Stable_Valid
);

  localparam logic [3:0] SAT = 4'(STABLE_COUNT);

  logic [3:0] r_run_count;
  digit_t     r_candidate;
  digit_t     r_stable_digit;
  logic       r_stable_valid;

  logic [3:0] w_next_run;
  digit_t     w_next_cand;

  // Next candidate/run length for a confident result; run length saturates.
  always_comb begin
    w_next_run  = 4'd1;
    w_next_cand = Digit;
    if ((Digit == r_candidate) && (r_run_count != 4'd0)) begin
      w_next_cand = r_candidate;
      w_next_run  = (r_run_count >= SAT) ? SAT : (r_run_count + 4'd1);
    end
  end

  // Filter state advances only on the scanner's commit pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_run_count    <= 4'd0;
      r_candidate    <= '0;
      r_stable_digit <= '0;
      r_stable_valid <= 1'b0;
    end else if (Update) begin
      if (!Confident) begin
        // Low-confidence frame breaks the run; keep the last shown digit.
        r_run_count    <= 4'd0;
        r_stable_valid <= 1'b0;
      end else begin
        r_run_count <= w_next_run;
        r_candidate <= w_next_cand;
        if (w_next_run == SAT) begin
          r_stable_digit <= w_next_cand;
          r_stable_valid <= 1'b1;
        end
      end
    end
  end

  assign Stable_Digit = r_stable_digit;
  assign Stable_Valid = r_stable_valid;

endmodule : prediction_filter

// File: rtl/prediction_selector.sv
// Sequential argmax over the network's probability vector, followed by a
// stability filter that feeds the HEX/LED display.
//
// Handshake: Start is a one-cycle pulse accepted only in IDLE; the vector is
// snapshotted on that edge. Busy is high from the accepting edge until the
// result commits. Done pulses for one cycle with Digit/Max_Prob/Confident and
// the filter outputs already updated. Start seen while Busy is dropped.
module prediction_selector
  import nn_pkg::*;
#(
  parameter int    STABLE_COUNT = 4,
  parameter prob_t MIN_CONF     = 16'h1000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  prob_t      Probability [NUM_CLASSES-1:0],
  output logic       Busy,
  output logic       Done,
  output digit_t     Digit,
  output prob_t      Max_Prob,
  output logic       Confident,
  output digit_t     Stable_Digit,
  output logic       Stable_Valid,
  output sel_state_t Dbg_State
);

  sel_state_t r_state;
  prob_t      r_snap [NUM_CLASSES-1:0];
  digit_t     r_idx;
  digit_t     r_best_idx;
  prob_t      r_best_val;
  logic       r_busy;
  logic       r_done;
  digit_t     r_digit;
  prob_t      r_max_prob;
  logic       r_confident;

  logic       w_commit;
  logic       w_best_conf;

  assign w_commit    = (r_state == COMMIT);
  assign w_best_conf = (r_best_val >= MIN_CONF);

  // Scanner FSM: capture, one comparison per cycle, then commit the winner.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_snap      <= '{default: '0};
      r_idx       <= '0;
      r_best_idx  <= '0;
      r_best_val  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_digit     <= '0;
      r_max_prob  <= '0;
      r_confident <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_snap     <= Probability;
            r_best_idx <= '0;
            r_best_val <= Probability[0];
            r_idx      <= 4'd1;
            r_busy     <= 1'b1;
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (r_snap[r_idx] > r_best_val) begin
            r_best_idx <= r_idx;
            r_best_val <= r_snap[r_idx];
          end
          r_idx <= r_idx + 4'd1;
          if (r_idx == LAST_IDX) begin
            r_state <= COMMIT;
          end
        end
        COMMIT: begin
          r_digit     <= r_best_idx;
          r_max_prob  <= r_best_val;
          r_confident <= w_best_conf;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  prediction_filter #(
    .STABLE_COUNT (STABLE_COUNT)
  ) u_filter (
    .Clk          (Clk),
    .Reset        (Reset),
    .Update       (w_commit),
    .Digit        (r_best_idx),
    .Confident    (w_best_conf),
    .Stable_Digit (Stable_Digit),
    .Stable_Valid (Stable_Valid)
  );

  assign Busy      = r_busy;
  assign Done      = r_done;
  assign Digit     = r_digit;
  assign Max_Prob  = r_max_prob;
  assign Confident = r_confident;
  assign Dbg_State = r_state;

endmodule : prediction_selector

// File: doc/prediction_selector.md
Name: prediction_selector

Overview:
- Consumes the 10-entry probability vector produced by neural_network and finds the winning digit by sequential argmax.
- Debounces that result across successive inferences, so the HEX/LED display shows a stable prediction instead of frame-to-frame flicker.
- Sits directly downstream of neural_network in the top level; Start is driven by the network's Ready pulse.

Parameters:
- NUM_CLASSES, 10, number of probability entries scanned (index width fixed at 4 bits).
- PROB_W, 16, width of each unsigned probability entry.
- STABLE_COUNT, 4, consecutive identical confident results required before Stable_Digit updates (range 1..15).
- MIN_CONF, 16'h1000, minimum winning probability counted as confident.

Ports:
- Clk  input  1  system clock (MAX10_CLK1_50 domain).
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle pulse; new Probability vector is valid.
- Probability  input  [PROB_W-1:0] x [NUM_CLASSES-1:0]  unpacked array, unsigned.
- Busy  output  1  high while a scan is in progress.
- Done  output  1  one-cycle pulse when Digit and Max_Prob update.
- Digit  output  4  argmax index of the last completed scan.
- Max_Prob  output  PROB_W  probability value at Digit.
- Confident  output  1  Max_Prob >= MIN_CONF for the last scan.
- Stable_Digit  output  4  debounced prediction.
- Stable_Valid  output  1  Stable_Digit is currently backed by confident results.

Behaviour:
- Reset (synchronous, any state): state=IDLE; all outputs 0; internal snapshot, candidate and run_count cleared. An in-flight scan is aborted and produces no Done.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - Start=1 copies the whole Probability array into an internal snapshot.
  - Sets best_idx=0, best_val=snap[0], idx=1; Busy goes to 1; next state SCAN.
  - Upstream changes after this edge have no effect on the scan.
- SCAN:
  - Each cycle, if snap[idx] > best_val (strictly greater, unsigned), then best_idx=idx and best_val=snap[idx].
  - idx increments by 1; after processing idx=NUM_CLASSES-1, next state COMMIT.
  - Ties resolve to the lowest index.
- COMMIT:
  - Digit=best_idx, Max_Prob=best_val, Confident=(best_val>=MIN_CONF).
  - Done=1 for exactly this one cycle; Busy=0; filter update as below; next state IDLE.
- Latency:
  - Done is registered high in the cycle after the 10th clock edge following the edge that sampled Start.
  - Start may be re-asserted in the cycle Done is high (state is already IDLE-bound) and is accepted on the next edge in IDLE.
- Start while Busy (SCAN or COMMIT) is ignored: no queueing, no restart.
- Digit, Max_Prob and Confident hold their values between scans.
- Stability filter (updated only in COMMIT):
  - If not confident: run_count=0, Stable_Valid=0, Stable_Digit held.
  - Else if best_idx==candidate and run_count>0: run_count = min(run_count+1, STABLE_COUNT).
  - Else: candidate=best_idx, run_count=1.
  - When the updated run_count==STABLE_COUNT: Stable_Digit=candidate, Stable_Valid=1.
  - A candidate change while Stable_Valid=1 keeps the old Stable_Digit and Stable_Valid=1 until the new candidate reaches STABLE_COUNT.
  - With STABLE_COUNT=1, every confident result updates Stable_Digit immediately.
- run_count saturates; it never wraps.

Decomposition:
- Shared package nn_pkg holds:
  - NUM_CLASSES and PROB_W constants;
  - typedef prob_t (logic [PROB_W-1:0]);
  - typedef digit_t (logic [3:0]);
  - enum sel_state_t {IDLE, SCAN, COMMIT}.
- neural_network and the top level also import this package.
- One sub-module, prediction_filter, contains the candidate/run_count/Stable_* logic.
  - Inputs: Clk, Reset, Update (the COMMIT pulse), Digit, Confident.
  - Testable alone.
- prediction_selector holds the snapshot, FSM and comparator.

Test Plan:
- Reset, then Start with Probability = {0,0,0,0,0,0,0,16'h8000,0,0} (index 7 high) -> Done exactly 10 edges after Start; Digit=7, Max_Prob=16'h8000, Confident=1; Busy high for those cycles.
- Tie: entries 2 and 5 both 16'h4000, others 0 -> Digit=2.
- Start, then change every Probability entry on the next cycle -> result reflects the captured vector only.
- Second Start asserted mid-scan -> ignored; exactly one Done.
- Four consecutive confident scans with winner 3 (STABLE_COUNT=4):
  - after scans 1–3, Stable_Valid=0;
  - after scan 4, Stable_Digit=3, Stable_Valid=1.
- Then two scans with winner 8 -> Stable_Digit stays 3.
- Then a scan with max 16'h0800 (< MIN_CONF) -> Confident=0, Stable_Valid=0, Stable_Digit=3.
- Reset asserted during SCAN -> no Done; all outputs 0 next cycle; a following Start completes normally.
